// File: rtl/hack_mem_pkg.sv
// -----------------------------------------------------------------------------
// hack_mem_pkg
// Shared constants and types for the Hack memory-side helpers.
//   ADDR_W      : RAM4K address width
//   DATA_W      : Hack word width
//   RAM4K_DEPTH : number of RAM4K words
//   LEN_W       : width of a word count that can express 0..RAM4K_DEPTH
//   loader_state_t : ram4k_loader phase encoding
// -----------------------------------------------------------------------------
package hack_mem_pkg;

    localparam int ADDR_W      = 12;
    localparam int DATA_W      = 16;
    localparam int RAM4K_DEPTH = 4096;
    localparam int LEN_W       = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } loader_state_t;

endpackage

// File: rtl/ram4k_loader_if.sv
// -----------------------------------------------------------------------------
// ram4k_loader_if
// Bundles the input word stream and the RAM4K pin bus of the loader.
//   in_data/in_valid/in_ready : valid/ready word stream into the loader
//   ram_in/ram_load/ram_address : loader drives RAM4K in/load/address
//   ram_out                   : RAM4K combinational read data back to loader
// Modports:
//   master : the loader side (drives in_ready and the RAM4K pins)
//   slave  : the environment side (stream source and RAM4K)
// -----------------------------------------------------------------------------
interface ram4k_loader_if #(
    parameter int ADDR_W = hack_mem_pkg::ADDR_W,
    parameter int DATA_W = hack_mem_pkg::DATA_W
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] ram_in;
    logic              ram_load;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_out;

    modport master (
        input  in_data,
        input  in_valid,
        input  ram_out,
        output in_ready,
        output ram_in,
        output ram_load,
        output ram_address
    );

    modport slave (
        output in_data,
        output in_valid,
        output ram_out,
        input  in_ready,
        input  ram_in,
        input  ram_load,
        input  ram_address
    );
endinterface

// File: rtl/ram4k_loader_addr_gen.sv
// -----------------------------------------------------------------------------
// ram4k_loader_addr_gen
// Word counter and address generator shared by the LOAD and VERIFY phases.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   latch_i       : capture base_i/len_i and clear the count
//   base_i        : first RAM address of the region
//   len_i         : number of words in the region (1..2**ADDR_W)
//   step_i        : one word handled this cycle; advance the count
//   addr_o        : (base + count) mod 2**ADDR_W
//   last_o        : current word is the final word of the region
// Stepping on the last word rolls the count back to zero so the next phase
// starts again at the base address without another latch.
// -----------------------------------------------------------------------------
module ram4k_loader_addr_gen #(
    parameter int ADDR_W = hack_mem_pkg::ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              latch_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);
    localparam logic [ADDR_W:0] CNT_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   len_q,  len_d;
    logic [ADDR_W:0]   count_q, count_d;

    // Count never exceeds 2**ADDR_W-1, so the truncated add wraps the address
    // exactly modulo the RAM depth.
    assign addr_o = base_q + count_q[ADDR_W-1:0];
    assign last_o = (count_q == (len_q - CNT_ONE));

    // Next-state for base latch, length latch and word counter.
    always_comb begin
        base_d  = base_q;
        len_d   = len_q;
        count_d = count_q;
        if (latch_i) begin
            base_d  = base_i;
            len_d   = len_i;
            count_d = CNT_ZERO;
        end else if (step_i) begin
            if (last_o) begin
                count_d = CNT_ZERO;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Register stage for the address generator state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q  <= {ADDR_W{1'b0}};
            len_q   <= CNT_ZERO;
            count_q <= CNT_ZERO;
        end else begin
            base_q  <= base_d;
            len_q   <= len_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/ram4k_loader.sv
// -----------------------------------------------------------------------------
// ram4k_loader
// Streams words into consecutive RAM4K addresses from a programmable base,
// then reads the region back and compares a running checksum.
//   CLK, RST_N : clock (rising edge), asynchronous active-low reset
//   start      : begin a load (only honoured in IDLE)
//   base_addr  : first RAM address, latched on start
//   length     : word count 0..4096, latched on start
//   bus        : stream in (in_data/in_valid/in_ready) and RAM4K pins
//                (ram_in/ram_load/ram_address/ram_out)
//   busy       : high in LOAD and VERIFY
//   done       : one-cycle completion pulse
//   error      : readback checksum mismatch, sticky until next accepted start
//   checksum   : load-phase word sum mod 2**DATA_W
// -----------------------------------------------------------------------------
module ram4k_loader #(
    parameter int ADDR_W = hack_mem_pkg::ADDR_W,
    parameter int DATA_W = hack_mem_pkg::DATA_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    ram4k_loader_if.master    bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] checksum
);
    import hack_mem_pkg::*;

    loader_state_t     state_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic [DATA_W-1:0] load_sum_q;
    logic [DATA_W-1:0] verify_sum_q;

    logic              accept_s;
    logic              xfer_s;
    logic              step_s;
    logic [ADDR_W-1:0] addr_s;
    logic              last_s;

    // Only a non-empty request needs the address generator; an empty one goes
    // straight to DONE without touching the RAM.
    assign accept_s = (state_q == ST_IDLE) && start && (length != {(ADDR_W+1){1'b0}});
    assign xfer_s   = (state_q == ST_LOAD) && bus.in_valid;
    assign step_s   = xfer_s || (state_q == ST_VERIFY);

    ram4k_loader_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .latch_i (accept_s),
        .base_i  (base_addr),
        .len_i   (length),
        .step_i  (step_s),
        .addr_o  (addr_s),
        .last_o  (last_s)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign checksum = load_sum_q;

    // RAM4K pins and in_ready decoded from the registered state. ram_load has
    // to follow in_valid within the same cycle, since RAM4K commits the word at
    // the edge that ends the transfer cycle.
    always_comb begin
        bus.in_ready    = 1'b0;
        bus.ram_load    = 1'b0;
        bus.ram_in      = {DATA_W{1'b0}};
        bus.ram_address = {ADDR_W{1'b0}};
        case (state_q)
            ST_LOAD: begin
                bus.in_ready    = 1'b1;
                bus.ram_load    = bus.in_valid;
                bus.ram_in      = bus.in_data;
                bus.ram_address = addr_s;
            end
            ST_VERIFY: begin
                bus.ram_address = addr_s;
            end
            ST_IDLE, ST_DONE: begin
                bus.ram_address = {ADDR_W{1'b0}};
            end
            default: begin
                bus.ram_address = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Phase sequencing, checksums and registered status outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            load_sum_q   <= {DATA_W{1'b0}};
            verify_sum_q <= {DATA_W{1'b0}};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        load_sum_q   <= {DATA_W{1'b0}};
                        verify_sum_q <= {DATA_W{1'b0}};
                        error_q      <= 1'b0;
                        if (accept_s) begin
                            state_q <= ST_LOAD;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (xfer_s) begin
                        load_sum_q <= load_sum_q + bus.in_data;
                        if (last_s) begin
                            state_q <= ST_VERIFY;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end else begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_VERIFY: begin
                    verify_sum_q <= verify_sum_q + bus.ram_out;
                    if (last_s) begin
                        // Compare including the final readback word so error
                        // is valid alongside the done pulse.
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        error_q <= ((verify_sum_q + bus.ram_out) != load_sum_q);
                    end else begin
                        state_q <= ST_VERIFY;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram4k_loader.sv
`timescale 1ns/1ps
module tb_ram4k_loader;

    typedef struct {
        logic [11:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] sum;
        logic        err;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] base_addr;
    logic [12:0] length;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] checksum;
    logic        corrupt;

    logic [15:0] mem     [4096] = '{default: 16'h0000};
    logic [15:0] ref_mem [4096] = '{default: 16'h0000};

    wr_t  exp_wr  [$];
    res_t exp_res [$];

    int n_checks = 0;
    int n_pass   = 0;

    localparam int BUDGET = 20000;

    ram4k_loader_if bus ();

    ram4k_loader dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    // RAM4K model: combinational read, write at the rising edge; optional
    // readback corruption of address 2.
    assign bus.ram_out = mem[bus.ram_address] ^
                         ((corrupt && (bus.ram_address == 12'd2)) ? 16'h0001 : 16'h0000);

    always @(posedge clk) begin
        if (bus.ram_load) mem[bus.ram_address] <= bus.ram_in;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every RAM write and every done pulse is matched against the
    // scoreboard queues filled by the stimulus side.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.ram_load) begin
                wr_t w;
                check("write_only_with_valid", bus.in_valid, 1);
                check("write_only_when_busy", busy, 1);
                check("write_expected", exp_wr.size() > 0, 1);
                if (exp_wr.size() > 0) begin
                    w = exp_wr.pop_front();
                    check("write_addr", bus.ram_address, w.addr);
                    check("write_data", bus.ram_in, w.data);
                end
            end
            if (done) begin
                res_t r;
                check("done_expected", exp_res.size() > 0, 1);
                if (exp_res.size() > 0) begin
                    r = exp_res.pop_front();
                    check("done_checksum", checksum, r.sum);
                    check("done_error", error, r.err);
                    check("done_busy_low", busy, 0);
                    check("done_addr_zero", bus.ram_address, 0);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_ram_load"}, bus.ram_load, 0);
        check({tag, "_ram_in"}, bus.ram_in, 0);
        check({tag, "_ram_address"}, bus.ram_address, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_checksum"}, checksum, 0);
    endtask

    task automatic check_ram(input string name);
        int mism = 0;
        for (int k = 0; k < 4096; k++) if (mem[k] !== ref_mem[k]) mism++;
        check(name, mism, 0);
    endtask

    // One load operation. The reference is the plain arithmetic description:
    // sum of the words mod 2^16, writes at (base+i) mod 4096, error exactly when
    // a corrupted address lies inside the region, and done after
    // 2*length+1 cycles plus one per stalled LOAD cycle.
    task automatic run_op(input logic [11:0] base, input int len, input int stall_pct,
                          input int stall_at, input bit incr, input bit corrupt_en,
                          input bit poke_start, input bit abort);
        logic [15:0] data [$];
        logic [15:0] sum = 16'h0000;
        bit          exp_err = 1'b0;
        int          c;
        int          i = 0;
        int          stalls = 0;
        int          held = 0;

        for (int k = 0; k < len; k++) begin
            data.push_back(incr ? 16'(k + 1) : 16'($urandom));
            sum = sum + data[k];
            if (corrupt_en && (((int'(base) + k) % 4096) == 2)) exp_err = 1'b1;
        end

        @(posedge clk); #1;
        corrupt   = corrupt_en;
        start     = 1'b1;
        base_addr = base;
        length    = 13'(len);
        exp_res.push_back('{sum: sum, err: exp_err});
        @(posedge clk); #1;
        start = 1'b0;
        c     = 1;
        check("start_clears_error", error, 0);

        while (i < len && c < BUDGET) begin
            check("in_ready_in_load", bus.in_ready, 1);
            if ((stall_at == i && held < 3) || ($urandom_range(99) < stall_pct)) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 16'($urandom);
                stalls++;
                if (stall_at == i) held++;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = data[i];
                exp_wr.push_back('{addr: 12'((int'(base) + i) % 4096), data: data[i]});
                ref_mem[(int'(base) + i) % 4096] = data[i];
                i++;
            end
            if (poke_start && c == 2) begin
                start  = 1'b1;
                length = 13'd0;
            end else begin
                start  = 1'b0;
            end
            @(posedge clk); #1;
            c++;
        end
        bus.in_valid = 1'b0;
        start        = 1'b0;

        if (abort) begin
            @(posedge clk); #1;
            check("verify_busy", busy, 1);
            rst_n = 1'b0;
            #1;
            check_all_zero("abort_reset");
            void'(exp_res.pop_back());
            @(posedge clk); #1;
            rst_n = 1'b1;
            corrupt = 1'b0;
            check_ram("abort_ram_contents");
            return;
        end

        while (done !== 1'b1 && c < BUDGET) begin
            @(posedge clk); #1;
            c++;
        end
        check("done_seen", done, 1);
        check("done_latency", c, 2 * len + 1 + stalls);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("checksum_held", checksum, sum);
        check("error_sticky", error, exp_err);
        corrupt = 1'b0;
        check_ram("ram_contents");
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        base_addr    = 12'd0;
        length       = 13'd0;
        corrupt      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // base, len, stall%, stall_at, incr, corrupt, poke, abort
        run_op(12'd0,    4,    0, -1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(12'd4094, 4,    0, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(12'd100,  12,   0,  5, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(12'($urandom), 20, 30, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(12'd0,    6,    0, -1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(12'd500,  3,    0, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(12'd77,   0,    0, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(12'd200,  8,    0, -1, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(12'd300,  5,    0, -1, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op(12'd50,   1,    0, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(12'd1234, 4096, 0, -1, 1'b0, 1'b0, 1'b0, 1'b0);

        check("writes_drained", exp_wr.size(), 0);
        check("results_drained", exp_res.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram4k_loader.md
# ram4k_loader

Streaming loader that sits directly upstream of the RAM4K block and drives its `in`, `load` and `address` pins. It accepts 16-bit words over a valid/ready stream and writes them to consecutive RAM4K addresses starting at a programmable base. It then reads the written region back through RAM4K `out` and checks a running checksum, so program and data images are confirmed before the Hack CPU is released.

## Interface
Parameters:
- `ADDR_W`, default 12: RAM4K address width.
- `DATA_W`, default 16: word width.

Ports:
- `CLK`  in  1: single clock, rising edge.
- `RST_N`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a load; sampled only in IDLE.
- `base_addr`  in  12: first RAM address; latched on start.
- `length`  in  13: word count, 0..4096; latched on start.
- `in_data`  in  16: stream word.
- `in_valid`  in  1: stream word present.
- `in_ready`  out  1: loader accepts a word.
- `ram_in`  out  16: to RAM4K `in`.
- `ram_load`  out  1: to RAM4K `load`.
- `ram_address`  out  12: to RAM4K `address`.
- `ram_out`  in  16: from RAM4K `out`; combinational read of `ram_address`.
- `busy`  out  1: high in LOAD and VERIFY.
- `done`  out  1: one-cycle pulse at completion.
- `error`  out  1: readback checksum mismatch; sticky until next accepted start.
- `checksum`  out  16: load-phase sum; held after done.

## Operation
- States: IDLE, LOAD, VERIFY, DONE.
- IDLE → LOAD when start=1 and length≠0. Latch base and length. Clear the counter, both sums and `error`.
- IDLE → DONE when start=1 and length=0. No RAM access. `error`=0. `checksum`=0.
- LOAD:
  - `in_ready`=1.
  - A transfer occurs on a cycle with in_valid&in_ready. On that cycle: `ram_load`=1, `ram_in`=`in_data`, `ram_address`=(base+count) mod 4096.
  - Each transfer adds `in_data` to the load sum (mod 2^16) and increments count.
  - After transfer number `length`, the next state is VERIFY and count clears.
  - `in_valid` low stalls the load indefinitely. No timeout.
- VERIFY:
  - `ram_load`=0, `in_ready`=0.
  - One word per cycle at `ram_address`=(base+count) mod 4096.
  - `ram_out` is added to the verify sum. After `length` reads, the next state is DONE.
- DONE:
  - Lasts one cycle. `done`=1. `error` is set if the verify sum ≠ load sum. Next state is IDLE.
- `start` in any state other than IDLE is ignored.
- Address wrap: base+count wraps modulo 4096. length=4096 covers every address exactly once.
- `ram_load` is never high outside LOAD. `ram_address`=0 in IDLE and DONE.

## Timing
- Reset (async assert, sync release) forces state IDLE. All outputs go to 0: `in_ready`, `ram_load`, `ram_in`, `ram_address`, `busy`, `done`, `error`, `checksum`.
- Reset during LOAD or VERIFY abandons the operation. RAM contents already written are not restored.
- Start latency: start seen at edge N; LOAD is active and `in_ready`=1 in cycle N+1.
- RAM write takes effect at the rising edge ending the transfer cycle. VERIFY's first read is in the cycle after the last transfer.
- Total cycles with no stalls, from start edge to done pulse: 2·length+1. For length=0, done is in cycle N+1.
- `checksum` is valid from the done cycle until the next accepted start.

## Structure
- Shared package `hack_mem_pkg`:
  - constants `ADDR_W`, `DATA_W`, `RAM4K_DEPTH`=4096;
  - loader state enum `loader_state_t`.
- One sub-module: `ram4k_loader_addr_gen`. It holds the 13-bit count, base latch, wrapped address, and terminal-count flag, and is reused by both phases.
- Sums and the FSM stay in the top module.

## Test plan
- Reset, then length=4, base=0, stream 1,2,3,4 with in_valid held high → RAM[0..3]=1..4, done in cycle 9 after start, checksum=10, error=0.
- base=4094, length=4, data A,B,C,D → writes land at 4094, 4095, 0, 1; error=0.
- in_valid toggled low for 3 cycles mid-stream → `in_ready` stays high, no `ram_load` while in_valid=0, final RAM contents correct.
- Bench RAM model corrupts the word at address 2 after LOAD → done with error=1. error clears on the next start.
- length=0 → done at N+1, `ram_load` never asserted. start pulsed during LOAD → ignored.
- RST_N asserted mid-VERIFY → all outputs 0 immediately. A new start with length=1 completes normally.
